// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter in front of a single-port data BRAM.
// Issues at most one registered access per cycle. A fixed-latency tag pipe
// returns read data only to the requester that issued the read.
// Optional build macro DMEM_ARB_FIXED_PRIO_EN: m0 wins every contention and
// the round-robin last_grant state is removed. If the macro is undefined,
// contention is resolved round-robin.
module dmem_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ready,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ready,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] d_addr,
  output logic [DATA_W-1:0] d_wdata,
  output logic              d_en,
  output logic              d_we,
  input  logic [DATA_W-1:0] d_rdata
);
  // One tag per cycle between issue and the cycle in which d_rdata is valid.
  localparam int TAGS = RD_LAT + 1;

  logic              grant0;
  logic              grant1;
  logic              grant_any;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  logic [ADDR_W-1:0] d_addr_q, d_addr_d;
  logic [DATA_W-1:0] d_wdata_q, d_wdata_d;
  logic              d_en_q, d_en_d;
  logic              d_we_q, d_we_d;

  logic [TAGS-1:0]   tag_vld_q, tag_vld_d;
  logic [TAGS-1:0]   tag_id_q, tag_id_d;

  logic              m0_rvalid_q, m0_rvalid_d;
  logic              m1_rvalid_q, m1_rvalid_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

`ifndef DMEM_ARB_FIXED_PRIO_EN
  // last_grant_q = 1 means m1 was granted most recently.
  logic last_grant_q, last_grant_d;

  // Remember the most recent winner. The value holds when there is no grant.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant1) begin
      last_grant_d = 1'b1;
    end else if (grant0) begin
      last_grant_d = 1'b0;
    end
  end

  // Round-robin state register. Reset favours m0 at the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // Grant decision. No requester is accepted while reset is asserted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      grant0 = m0_req;
      grant1 = m1_req & ~m0_req;
`else
      grant0 = m0_req & (~m1_req | last_grant_q);
      grant1 = m1_req & (~m0_req | ~last_grant_q);
`endif
    end
  end

  assign grant_any = grant0 | grant1;
  assign m0_ready  = grant0;
  assign m1_ready  = grant1;
  assign win_we    = grant1 ? m1_we    : m0_we;
  assign win_addr  = grant1 ? m1_addr  : m0_addr;
  assign win_wdata = grant1 ? m1_wdata : m0_wdata;

  // Next BRAM command. Address and data hold when the port is idle.
  always_comb begin
    d_addr_d  = d_addr_q;
    d_wdata_d = d_wdata_q;
    d_en_d    = grant_any;
    d_we_d    = grant_any & win_we;
    if (grant_any) begin
      d_addr_d  = win_addr;
      d_wdata_d = win_wdata;
    end
  end

  // Stage 0 records a read and its issuer. Later stages shift every cycle.
  assign tag_vld_d[0] = grant_any & ~win_we;
  assign tag_id_d[0]  = grant1;
  for (genvar gi = 1; gi < TAGS; gi++) begin : g_tag_shift
    assign tag_vld_d[gi] = tag_vld_q[gi-1];
    assign tag_id_d[gi]  = tag_id_q[gi-1];
  end

  // Route d_rdata to the issuer when the last tag stage lines up with it.
  always_comb begin
    m0_rvalid_d = tag_vld_q[TAGS-1] & ~tag_id_q[TAGS-1];
    m1_rvalid_d = tag_vld_q[TAGS-1] & tag_id_q[TAGS-1];
    m0_rdata_d  = m0_rvalid_d ? d_rdata : m0_rdata_q;
    m1_rdata_d  = m1_rvalid_d ? d_rdata : m1_rdata_q;
  end

  // Register the BRAM command, the tag pipe and the read responses.
  // Reset drops every in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_addr_q    <= '0;
      d_wdata_q   <= '0;
      d_en_q      <= 1'b0;
      d_we_q      <= 1'b0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      d_addr_q    <= d_addr_d;
      d_wdata_q   <= d_wdata_d;
      d_en_q      <= d_en_d;
      d_we_q      <= d_we_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign d_addr    = d_addr_q;
  assign d_wdata   = d_wdata_q;
  assign d_en      = d_en_q;
  assign d_we      = d_we_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter. It uses a behavioural single-port BRAM with
// RD_LAT output registers. A vector table covers idle cycles and continuous
// contention. Hand-written sequences cover the multi-cycle corner cases.
module tb_dmem_arbiter;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;

  logic              clk;
  logic              rst;
  logic              m0_req, m0_we, m0_ready, m0_rvalid;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata, m0_rdata;
  logic              m1_req, m1_we, m1_ready, m1_rvalid;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata, m1_rdata;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic              d_en, d_we;

  int n_cmp = 0;
  int n_err = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_en(d_en), .d_we(d_we),
    .d_rdata(d_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural BRAM: it is preloaded through a side port while reset is
  // high. Read data appears RD_LAT cycles after the enable is sampled.
  logic              pl_en;
  logic [8:0]        pl_addr;
  logic [DATA_W-1:0] pl_data;
  logic [DATA_W-1:0] mem [0:511];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (d_en && d_we) mem[d_addr[8:0]] <= d_wdata;
    if (d_en) rd_pipe[0] <= mem[d_addr[8:0]];
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign d_rdata = rd_pipe[RD_LAT-1];

  typedef struct {
    logic              m0_req;
    logic [ADDR_W-1:0] m0_addr;
    logic              m1_req;
    logic [ADDR_W-1:0] m1_addr;
    logic              e_rdy0;
    logic              e_rdy1;
    logic              e_en;
    logic [ADDR_W-1:0] e_addr;
    logic              e_rv0;
    logic [DATA_W-1:0] e_rd0;
    logic              e_rv1;
    logic [DATA_W-1:0] e_rd1;
  } vec_t;

  vec_t vecs [0:22];

  function automatic vec_t mk(input logic r0, input logic [ADDR_W-1:0] a0,
                              input logic r1, input logic [ADDR_W-1:0] a1,
                              input logic y0, input logic y1, input logic en,
                              input logic [ADDR_W-1:0] ea,
                              input logic v0, input logic [DATA_W-1:0] d0,
                              input logic v1, input logic [DATA_W-1:0] d1);
    vec_t v;
    v.m0_req = r0; v.m0_addr = a0; v.m1_req = r1; v.m1_addr = a1;
    v.e_rdy0 = y0; v.e_rdy1 = y1; v.e_en = en; v.e_addr = ea;
    v.e_rv0 = v0; v.e_rd0 = d0; v.e_rv1 = v1; v.e_rd1 = d1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
  endtask

  // Watchdog: every sequence below is fixed-length, so this only guards
  // against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  localparam logic [DATA_W-1:0] A1 = 32'h1111_0001;
  localparam logic [DATA_W-1:0] B2 = 32'h2222_0002;

  logic [8:0]        pl_a [7];
  logic [DATA_W-1:0] pl_v [7];

  initial begin
    pl_a[0] = 9'h001; pl_v[0] = A1;
    pl_a[1] = 9'h002; pl_v[1] = B2;
    pl_a[2] = 9'h003; pl_v[2] = 32'h0000_000A;
    pl_a[3] = 9'h004; pl_v[3] = 32'h0000_000B;
    pl_a[4] = 9'h005; pl_v[4] = 32'h0000_000C;
    pl_a[5] = 9'h010; pl_v[5] = 32'hDEAD_BEEF;
    pl_a[6] = 9'h100; pl_v[6] = 32'h5555_AAAA;

    // Rows 0-9 are idle after reset. Rows 10-17 have both requesters
    // reading continuously. Rows 18-22 drain the reads still in flight.
    for (int i = 0; i < 10; i++) vecs[i] = mk(0,0,0,0, 0,0,0,0, 0,0,0,0);
    vecs[10] = mk(1,1,1,2, 1,0, 0,0, 0,0,  0,0);
    vecs[11] = mk(1,1,1,2, 0,1, 1,1, 0,0,  0,0);
    vecs[12] = mk(1,1,1,2, 1,0, 1,2, 0,0,  0,0);
    vecs[13] = mk(1,1,1,2, 0,1, 1,1, 0,0,  0,0);
    vecs[14] = mk(1,1,1,2, 1,0, 1,2, 1,A1, 0,0);
    vecs[15] = mk(1,1,1,2, 0,1, 1,1, 0,A1, 1,B2);
    vecs[16] = mk(1,1,1,2, 1,0, 1,2, 1,A1, 0,B2);
    vecs[17] = mk(1,1,1,2, 0,1, 1,1, 0,A1, 1,B2);
    vecs[18] = mk(0,0,0,0, 0,0, 1,2, 1,A1, 0,B2);
    vecs[19] = mk(0,0,0,0, 0,0, 0,2, 0,A1, 1,B2);
    vecs[20] = mk(0,0,0,0, 0,0, 0,2, 1,A1, 0,B2);
    vecs[21] = mk(0,0,0,0, 0,0, 0,2, 0,A1, 1,B2);
    vecs[22] = mk(0,0,0,0, 0,0, 0,2, 0,A1, 0,B2);

    rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    idle_inputs();
    step();

    // Reset phase: preload the BRAM while both requesters ask to write.
    // No ready may be given while reset is high.
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 'h10; m0_wdata = 32'hBAD0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 'h11; m1_wdata = 32'hBAD1;
    for (int i = 0; i < 7; i++) begin
      pl_en = 1'b1; pl_addr = pl_a[i]; pl_data = pl_v[i];
      @(negedge clk);
      chk("rst_rdy0", m0_ready, 0);
      chk("rst_rdy1", m1_ready, 0);
      if (i == 6) begin
        chk("rst_den", d_en, 0);
        chk("rst_dwe", d_we, 0);
        chk("rst_daddr", d_addr, 0);
        chk("rst_dwdata", d_wdata, 0);
        chk("rst_rv0", m0_rvalid, 0);
        chk("rst_rv1", m1_rvalid, 0);
        chk("rst_rd0", m0_rdata, 0);
        chk("rst_rd1", m1_rdata, 0);
      end
      step();
    end
    pl_en = 1'b0;
    rst = 1'b0;
    idle_inputs();

    // Table: the idle period first, then round-robin contention.
    for (int i = 0; i <= 22; i++) begin
      m0_req = vecs[i].m0_req; m0_we = 1'b0; m0_addr = vecs[i].m0_addr;
      m1_req = vecs[i].m1_req; m1_we = 1'b0; m1_addr = vecs[i].m1_addr;
      @(negedge clk);
      $display("vec %0d: m0_req=%0d m1_req=%0d rdy=%0d%0d d_en=%0d d_addr=0x%0h rv=%0d%0d",
               i, m0_req, m1_req, m0_ready, m1_ready, d_en, d_addr, m0_rvalid, m1_rvalid);
      chk($sformatf("v%0d_rdy0", i), m0_ready, vecs[i].e_rdy0);
      chk($sformatf("v%0d_rdy1", i), m1_ready, vecs[i].e_rdy1);
      chk($sformatf("v%0d_den", i), d_en, vecs[i].e_en);
      chk($sformatf("v%0d_dwe", i), d_we, 0);
      chk($sformatf("v%0d_daddr", i), d_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_rv0", i), m0_rvalid, vecs[i].e_rv0);
      chk($sformatf("v%0d_rd0", i), m0_rdata, vecs[i].e_rd0);
      chk($sformatf("v%0d_rv1", i), m1_rvalid, vecs[i].e_rv1);
      chk($sformatf("v%0d_rd1", i), m1_rdata, vecs[i].e_rd1);
      step();
    end
    idle_inputs();

    // Single m0 read of 0x10. The issue appears one cycle later and rvalid four cycles later.
    $display("seq1: m0 read 0x10");
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 'h10;
    @(negedge clk);
    chk("s1_rdy0", m0_ready, 1);
    chk("s1_rdy1", m1_ready, 0);
    step();
    m0_req = 1'b0;
    @(negedge clk);
    chk("s1_den", d_en, 1);
    chk("s1_dwe", d_we, 0);
    chk("s1_daddr", d_addr, 'h10);
    for (int k = 2; k <= 5; k++) begin
      step();
      @(negedge clk);
      chk($sformatf("s1_rv0_c%0d", k), m0_rvalid, (k == 4));
      chk($sformatf("s1_rv1_c%0d", k), m1_rvalid, 0);
      if (k == 4) chk("s1_rd0", m0_rdata, 32'hDEAD_BEEF);
    end
    step();

    // m1 writes 0x100, then m0 reads 0x100 and sees the new data.
    $display("seq3: m1 write 0x100, m0 read 0x100");
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 'h100; m1_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("s3_rdy1", m1_ready, 1);
    step();
    m1_req = 1'b0; m1_we = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 'h100;
    @(negedge clk);
    chk("s3_rdy0", m0_ready, 1);
    chk("s3_wr_den", d_en, 1);
    chk("s3_wr_dwe", d_we, 1);
    chk("s3_wr_daddr", d_addr, 'h100);
    chk("s3_wr_dwdata", d_wdata, 32'h1234_5678);
    step();
    m0_req = 1'b0;
    @(negedge clk);
    chk("s3_rd_den", d_en, 1);
    chk("s3_rd_dwe", d_we, 0);
    chk("s3_rd_daddr", d_addr, 'h100);
    for (int k = 3; k <= 7; k++) begin
      step();
      @(negedge clk);
      chk($sformatf("s3_rv0_c%0d", k), m0_rvalid, (k == 5));
      chk($sformatf("s3_rv1_c%0d", k), m1_rvalid, 0);
      if (k == 5) chk("s3_rd0", m0_rdata, 32'h1234_5678);
    end
    step();

    // m0 issues three back-to-back reads. Responses arrive in order on consecutive cycles.
    $display("seq4: m0 reads 0x3, 0x4, 0x5");
    for (int k = 0; k < 3; k++) begin
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = ADDR_W'(3 + k);
      @(negedge clk);
      chk($sformatf("s4_rdy0_%0d", k), m0_ready, 1);
      step();
    end
    m0_req = 1'b0;
    for (int k = 3; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("s4_rv0_c%0d", k), m0_rvalid, (k >= 4 && k <= 6));
      chk($sformatf("s4_rv1_c%0d", k), m1_rvalid, 0);
      if (k >= 4 && k <= 6) chk($sformatf("s4_rd0_c%0d", k), m0_rdata, 32'hA + (k - 4));
      step();
    end

    // m0 read, then reset for one cycle. The read is discarded, the write
    // requested during reset is never issued, and m0 wins the first
    // contention after reset.
    $display("seq5: read, reset, contention after reset");
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 'h10;
    @(negedge clk);
    chk("s5_rdy0", m0_ready, 1);
    step();
    rst = 1'b1;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 'h5; m1_wdata = 32'hBAD5;
    @(negedge clk);
    chk("s5_rst_rdy0", m0_ready, 0);
    chk("s5_rst_rdy1", m1_ready, 0);
    step();
    rst = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 'h4;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 'h5;
    @(negedge clk);
    chk("s5_den", d_en, 0);
    chk("s5_dwe", d_we, 0);
    chk("s5_daddr", d_addr, 0);
    chk("s5_cont_rdy0", m0_ready, 1);
    chk("s5_cont_rdy1", m1_ready, 0);
    step();
    m0_req = 1'b0;
    @(negedge clk);
    chk("s5_rdy1", m1_ready, 1);
    chk("s5_den2", d_en, 1);
    chk("s5_daddr2", d_addr, 'h4);
    step();
    m1_req = 1'b0;
    for (int k = 4; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("s5_rv0_c%0d", k), m0_rvalid, (k == 6));
      chk($sformatf("s5_rv1_c%0d", k), m1_rvalid, (k == 7));
      if (k == 6) chk("s5_rd0", m0_rdata, 32'h0000_000B);
      if (k == 7) chk("s5_rd1", m1_rdata, 32'h0000_000C);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
